// File: rtl/axil_window_bridge.sv
// AXI4-Lite bridge relocating up to NUM_WIN address windows onto a master port.
// Define AXIL_BRIDGE_BSWAP_EN to byte-swap data and strobes for big-endian targets.
module axil_window_bridge #(
   parameter int                    NUM_WIN    = 1,
   parameter logic [32*NUM_WIN-1:0] WIN_BASE   = '0,
   parameter logic [32*NUM_WIN-1:0] WIN_SIZE   = {NUM_WIN{32'h1000_0000}},
   parameter logic [32*NUM_WIN-1:0] WIN_OFFSET = '0,
   parameter int                    DATA_WIDTH = 32,
   parameter int                    DEST_WIDTH = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [31:0]             s_araddr,
   input  logic                    s_arvalid,
   input  logic [2:0]              s_arprot,
   output logic                    s_arready,
   output logic [DATA_WIDTH-1:0]   s_rdata,
   output logic [1:0]              s_rresp,
   output logic                    s_rvalid,
   input  logic                    s_rready,
   input  logic [31:0]             s_awaddr,
   input  logic                    s_awvalid,
   input  logic [2:0]              s_awprot,
   output logic                    s_awready,
   input  logic [DATA_WIDTH-1:0]   s_wdata,
   input  logic [DATA_WIDTH/8-1:0] s_wstrb,
   input  logic                    s_wvalid,
   output logic                    s_wready,
   output logic [1:0]              s_bresp,
   output logic                    s_bvalid,
   input  logic                    s_bready,
   output logic [DEST_WIDTH-1:0]   m_araddr,
   output logic                    m_arvalid,
   output logic [2:0]              m_arprot,
   input  logic                    m_arready,
   input  logic [DATA_WIDTH-1:0]   m_rdata,
   input  logic [1:0]              m_rresp,
   input  logic                    m_rvalid,
   output logic                    m_rready,
   output logic [DEST_WIDTH-1:0]   m_awaddr,
   output logic                    m_awvalid,
   output logic [2:0]              m_awprot,
   input  logic                    m_awready,
   output logic [DATA_WIDTH-1:0]   m_wdata,
   output logic [DATA_WIDTH/8-1:0] m_wstrb,
   output logic                    m_wvalid,
   input  logic                    m_wready,
   input  logic [1:0]              m_bresp,
   input  logic                    m_bvalid,
   output logic                    m_bready
);

   localparam int STRB_W = DATA_WIDTH / 8;

   typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA, R_RESP} r_state_e;
   typedef enum logic [1:0] {W_IDLE, W_REQ, W_RESP, W_DONE} w_state_e;

   // {hit, translated address}; loop runs downward so the lowest index wins
   function automatic logic [32:0] decode(input logic [31:0] a);
      logic [32:0] r;
      r = '0;
      for (int i = NUM_WIN - 1; i >= 0; i--) begin
         if ((a & ~(WIN_SIZE[32*i+:32] - 32'd1)) == WIN_BASE[32*i+:32])
            r = {1'b1, a - WIN_BASE[32*i+:32] + WIN_OFFSET[32*i+:32]};
      end
      return r;
   endfunction

`ifdef AXIL_BRIDGE_BSWAP_EN
   function automatic logic [DATA_WIDTH-1:0] swap_d(input logic [DATA_WIDTH-1:0] d);
      logic [DATA_WIDTH-1:0] r;
      for (int i = 0; i < STRB_W; i++) r[8*i+:8] = d[DATA_WIDTH-8-8*i+:8];
      return r;
   endfunction
   function automatic logic [STRB_W-1:0] swap_s(input logic [STRB_W-1:0] s);
      logic [STRB_W-1:0] r;
      for (int i = 0; i < STRB_W; i++) r[i] = s[STRB_W-1-i];
      return r;
   endfunction
`else
   function automatic logic [DATA_WIDTH-1:0] swap_d(input logic [DATA_WIDTH-1:0] d);
      return d;
   endfunction
   function automatic logic [STRB_W-1:0] swap_s(input logic [STRB_W-1:0] s);
      return s;
   endfunction
`endif

   r_state_e                r_state_q;
   w_state_e                w_state_q;
   logic                    s_arready_q, s_rvalid_q, m_arvalid_q, m_rready_q;
   logic [DATA_WIDTH-1:0]   s_rdata_q;
   logic [1:0]              s_rresp_q, s_bresp_q;
   logic [DEST_WIDTH-1:0]   m_araddr_q, m_awaddr_q;
   logic [2:0]              m_arprot_q, m_awprot_q, awprot_q;
   logic                    s_awready_q, s_wready_q, s_bvalid_q;
   logic                    m_awvalid_q, m_wvalid_q, m_bready_q;
   logic [31:0]             awaddr_q;
   logic [DATA_WIDTH-1:0]   wdata_q, m_wdata_q;
   logic [STRB_W-1:0]       wstrb_q, m_wstrb_q;

   logic [32:0]             ar_dec_d, aw_dec_d;
   logic [DATA_WIDTH-1:0]   wdata_d;
   logic [STRB_W-1:0]       wstrb_d;
   logic [2:0]              awprot_d;
   logic                    aw_hs, w_hs, both_d, req_done;

   assign aw_hs    = s_awvalid & s_awready_q;
   assign w_hs     = s_wvalid & s_wready_q;
   assign both_d   = (aw_hs | ~s_awready_q) & (w_hs | ~s_wready_q);
   assign ar_dec_d = decode(s_araddr);
   assign aw_dec_d = decode(aw_hs ? s_awaddr : awaddr_q);
   assign awprot_d = aw_hs ? s_awprot : awprot_q;
   assign wdata_d  = w_hs ? s_wdata : wdata_q;
   assign wstrb_d  = w_hs ? s_wstrb : wstrb_q;
   assign req_done = (~m_awvalid_q | m_awready) & (~m_wvalid_q | m_wready);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state_q   <= R_IDLE;
         s_arready_q <= 1'b1;
         s_rvalid_q  <= 1'b0;
         s_rdata_q   <= '0;
         s_rresp_q   <= 2'b00;
         m_arvalid_q <= 1'b0;
         m_araddr_q  <= '0;
         m_arprot_q  <= 3'b000;
         m_rready_q  <= 1'b0;
      end else begin
         unique case (r_state_q)
            R_IDLE: if (s_arvalid) begin
               s_arready_q <= 1'b0;
               if (ar_dec_d[32]) begin
                  m_arvalid_q <= 1'b1;
                  m_araddr_q  <= ar_dec_d[DEST_WIDTH-1:0];
                  m_arprot_q  <= s_arprot;
                  r_state_q   <= R_ADDR;
               end else begin
                  s_rvalid_q <= 1'b1;
                  s_rdata_q  <= '0;
                  s_rresp_q  <= 2'b11;
                  r_state_q  <= R_RESP;
               end
            end
            R_ADDR: if (m_arready) begin
               m_arvalid_q <= 1'b0;
               m_rready_q  <= 1'b1;
               r_state_q   <= R_DATA;
            end
            R_DATA: if (m_rvalid) begin
               m_rready_q <= 1'b0;
               s_rvalid_q <= 1'b1;
               s_rdata_q  <= swap_d(m_rdata);
               s_rresp_q  <= m_rresp;
               r_state_q  <= R_RESP;
            end
            R_RESP: if (s_rready) begin
               s_rvalid_q  <= 1'b0;
               s_arready_q <= 1'b1;
               r_state_q   <= R_IDLE;
            end
            default: r_state_q <= R_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         w_state_q   <= W_IDLE;
         s_awready_q <= 1'b1;
         s_wready_q  <= 1'b1;
         s_bvalid_q  <= 1'b0;
         s_bresp_q   <= 2'b00;
         awaddr_q    <= '0;
         awprot_q    <= 3'b000;
         wdata_q     <= '0;
         wstrb_q     <= '0;
         m_awvalid_q <= 1'b0;
         m_awaddr_q  <= '0;
         m_awprot_q  <= 3'b000;
         m_wvalid_q  <= 1'b0;
         m_wdata_q   <= '0;
         m_wstrb_q   <= '0;
         m_bready_q  <= 1'b0;
      end else begin
         unique case (w_state_q)
            W_IDLE: begin
               if (aw_hs) begin
                  s_awready_q <= 1'b0;
                  awaddr_q    <= s_awaddr;
                  awprot_q    <= s_awprot;
               end
               if (w_hs) begin
                  s_wready_q <= 1'b0;
                  wdata_q    <= s_wdata;
                  wstrb_q    <= s_wstrb;
               end
               if (both_d && aw_dec_d[32]) begin
                  m_awvalid_q <= 1'b1;
                  m_awaddr_q  <= aw_dec_d[DEST_WIDTH-1:0];
                  m_awprot_q  <= awprot_d;
                  m_wvalid_q  <= 1'b1;
                  m_wdata_q   <= swap_d(wdata_d);
                  m_wstrb_q   <= swap_s(wstrb_d);
                  w_state_q   <= W_REQ;
               end else if (both_d) begin
                  s_bvalid_q <= 1'b1;
                  s_bresp_q  <= 2'b11;
                  w_state_q  <= W_DONE;
               end
            end
            W_REQ: begin
               if (m_awready) m_awvalid_q <= 1'b0;
               if (m_wready) m_wvalid_q <= 1'b0;
               if (req_done) begin
                  m_bready_q <= 1'b1;
                  w_state_q  <= W_RESP;
               end
            end
            W_RESP: if (m_bvalid) begin
               m_bready_q <= 1'b0;
               s_bvalid_q <= 1'b1;
               s_bresp_q  <= m_bresp;
               w_state_q  <= W_DONE;
            end
            W_DONE: if (s_bready) begin
               s_bvalid_q  <= 1'b0;
               s_awready_q <= 1'b1;
               s_wready_q  <= 1'b1;
               w_state_q   <= W_IDLE;
            end
            default: w_state_q <= W_IDLE;
         endcase
      end
   end

   assign s_arready = s_arready_q;
   assign s_rvalid  = s_rvalid_q;
   assign s_rdata   = s_rdata_q;
   assign s_rresp   = s_rresp_q;
   assign m_arvalid = m_arvalid_q;
   assign m_araddr  = m_araddr_q;
   assign m_arprot  = m_arprot_q;
   assign m_rready  = m_rready_q;
   assign s_awready = s_awready_q;
   assign s_wready  = s_wready_q;
   assign s_bvalid  = s_bvalid_q;
   assign s_bresp   = s_bresp_q;
   assign m_awvalid = m_awvalid_q;
   assign m_awaddr  = m_awaddr_q;
   assign m_awprot  = m_awprot_q;
   assign m_wvalid  = m_wvalid_q;
   assign m_wdata   = m_wdata_q;
   assign m_wstrb   = m_wstrb_q;
   assign m_bready  = m_bready_q;

endmodule
